// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 32x16 GPR ALU datapath.
// It fetches over a req/ack port, strobes ALU execution, captures flags, and resolves jumps, NOP and HALT.
module instr_sequencer #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir_out,
  output logic              exec_en,
  input  logic              sign_in,
  input  logic              zero_in,
  input  logic              carry_in,
  input  logic              overflow_in,
  output logic [3:0]        flags_q,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  instr_cnt
);

  localparam logic [4:0] OP_JMP  = 5'd12;
  localparam logic [4:0] OP_JC   = 5'd13;
  localparam logic [4:0] OP_JNC  = 5'd14;
  localparam logic [4:0] OP_JS   = 5'd15;
  localparam logic [4:0] OP_JNS  = 5'd16;
  localparam logic [4:0] OP_JZ   = 5'd17;
  localparam logic [4:0] OP_JNZ  = 5'd18;
  localparam logic [4:0] OP_JV   = 5'd19;
  localparam logic [4:0] OP_JNV  = 5'd20;
  localparam logic [4:0] OP_HALT = 5'd22;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_CAPTURE,
    S_HALT
  } state_t;

  state_t            state;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic              take_branch;
  logic [4:0]        op;
  logic              is_alu;
  logic              is_undef;
  logic              cond_met;

  assign op       = ir[31:27];
  assign is_alu   = (op < OP_JMP);
  assign is_undef = (op > OP_HALT);

  // flags_q holds {sign, zero, carry, overflow} from the most recent ALU op
  always_comb begin
    cond_met = 1'b0;
    case (op)
      OP_JMP:  cond_met = 1'b1;
      OP_JC:   cond_met = flags_q[1];
      OP_JNC:  cond_met = ~flags_q[1];
      OP_JS:   cond_met = flags_q[3];
      OP_JNS:  cond_met = ~flags_q[3];
      OP_JZ:   cond_met = flags_q[2];
      OP_JNZ:  cond_met = ~flags_q[2];
      OP_JV:   cond_met = flags_q[0];
      OP_JNV:  cond_met = ~flags_q[0];
      default: cond_met = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ir          <= '0;
      pc          <= '0;
      flags_q     <= '0;
      instr_cnt   <= '0;
      take_branch <= 1'b0;
      imem_req    <= 1'b0;
      exec_en     <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      exec_en    <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc       <= '0;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (op == OP_HALT) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
            busy      <= 1'b0;
            halted    <= 1'b1;
            state     <= S_HALT;
          end else begin
            exec_en    <= is_alu;
            illegal_op <= is_undef;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          take_branch <= cond_met;
          state       <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (is_alu)
            flags_q <= {sign_in, zero_in, carry_in, overflow_in};
          pc          <= take_branch ? ir[ADDR_W-1:0] : pc + ADDR_W'(1);
          instr_cnt   <= instr_cnt + CNT_W'(1);
          take_branch <= 1'b0;
          imem_req    <= 1'b1;
          state       <= S_FETCH;
        end
        S_HALT: begin
          if (start) begin
            pc       <= '0;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            halted   <= 1'b0;
            state    <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign ir_out    = ir;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the 32-entry x 16-bit GPR ALU datapath.
- Fetches 32-bit instructions from program memory through a req/ack handshake and presents them as IR to the datapath.
- Strobes execution of ALU ops and captures the datapath condition flags (sign, zero, carry, overflow).
- Resolves jumps, NOP and HALT locally; maintains PC and a retired-instruction counter.

Parameters:
ADDR_W, 8, program-memory address width; PC wraps modulo 2^ADDR_W
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level/pulse; leaves IDLE or HALT, begins execution at PC=0
imem_req  output  1  fetch request, held until ack
imem_addr  output  ADDR_W  fetch address (equals PC), stable while imem_req=1
imem_ack  input  1  memory returns data this cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
ir_out  output  32  current IR to datapath: [31:27] op, [26:22] rdst, [21:17] rsrc1, [16] imm_mode, [15:11] rsrc2, [15:0] imm
exec_en  output  1  one-cycle datapath execute strobe
sign_in, zero_in, carry_in, overflow_in  input  1 each  datapath flags
flags_q  output  4  registered {sign, zero, carry, overflow}
pc_out  output  ADDR_W  current PC
busy  output  1  high in FETCH/DECODE/EXEC/CAPTURE
halted  output  1  high in HALT
illegal_op  output  1  one-cycle pulse on undefined opcode
instr_cnt  output  CNT_W  retired instructions, wraps at 2^CNT_W

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0 (pc, ir_out, flags_q, instr_cnt, imem_req, exec_en, busy, halted, illegal_op). Reset mid-transaction drops imem_req immediately; any pending ack is ignored.
- Opcode classes:
  - ALU: 0-11 (movsgpr, mov, add, sub, mul, or, and, xor, xnor, nand, nor, not).
  - Control: 12 JMP, 13 JC, 14 JNC, 15 JS, 16 JNS, 17 JZ, 18 JNZ, 19 JV, 20 JNV, 21 NOP, 22 HALT.
  - 23-31 undefined.
- Jump target = ir[ADDR_W-1:0].
- States:
  - IDLE: start=1 -> FETCH with pc=0.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack: latch imem_rdata into IR, drop req, go to DECODE. Ack without req is ignored. Waits indefinitely.
  - DECODE: 1 cycle; classify op. HALT -> HALT state: instr_cnt+1, pc unchanged.
  - EXEC: 1 cycle; exec_en=1 only for ALU ops. Branch condition evaluated against flags_q (flags from the last ALU op). Undefined op: illegal_op=1 for this cycle, treated as NOP.
  - CAPTURE: 1 cycle.
    - ALU op: flags_q <= {sign_in, zero_in, carry_in, overflow_in}. Non-ALU ops leave flags_q unchanged.
    - pc <= taken ? target : pc+1 (wraps modulo 2^ADDR_W).
    - instr_cnt+1. Next state FETCH.
  - HALT: halted=1, busy=0, no req. start=1 -> pc=0, FETCH. flags_q and instr_cnt are kept.
- Timing:
  - Zero-wait memory (ack in first FETCH cycle): 4 cycles per instruction.
  - Each ack wait cycle adds 1 cycle.
- ir_out changes only on the ack capture edge and is stable through EXEC/CAPTURE, so the combinational datapath settles before CAPTURE samples the flags.
- start is ignored while busy.

Test Plan:
1. Reset, start; mem[0]=ADI rdst0 rsrc1=2 imm4, zero-wait ack -> exec_en high exactly 1 cycle, 3 cycles after req; pc 0->1; instr_cnt=1; 4 cycles/instr.
2. Ack delayed 3 cycles -> imem_req stays high, imem_addr stable, ir_out unchanged until the ack edge; instruction takes 7 cycles.
3. add 0x8000+0x8002 drives carry_in=1, overflow_in=1 -> flags_q=0011. Next JC 0x20 -> pc=0x20, no exec_en. A later JZ with zero=0 -> pc=0x21.
4. JMP 0xFF then NOP at 0xFF -> next imem_addr=0x00 (wrap).
5. HALT at pc=5 -> halted=1, busy=0, imem_req=0, pc=5. start -> fetch from 0x00; instr_cnt keeps counting.
6. Opcode 31 -> illegal_op single pulse, no exec_en, flags_q unchanged, pc+1. Assert rst_n=0 mid-FETCH -> imem_req=0 and all outputs 0 asynchronously.
